// File: rtl/uart_alu_sequencer_pkg.sv
// rtl/uart_alu_sequencer_pkg.sv - shared types, opcodes and helpers for the UART/ALU sequencer
//
// Package uart_alu_pkg:
//   OP_W              opcode field width understood by is_valid_op
//   OP_ADD .. OP_SRL  ALU opcode encodings
//   ERR_BYTE_DEFAULT  byte sent back in place of a result for a bad opcode
//   ST_*, state_e     sequencer FSM state encodings
//   is_valid_op()     true when an opcode field is one of the supported ALU operations
package uart_alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

    localparam logic [2:0] ST_WAIT_A    = 3'd0;
    localparam logic [2:0] ST_WAIT_B    = 3'd1;
    localparam logic [2:0] ST_WAIT_OP   = 3'd2;
    localparam logic [2:0] ST_EXEC      = 3'd3;
    localparam logic [2:0] ST_SEND_WAIT = 3'd4;

    typedef enum logic [2:0] {
        WAIT_A    = ST_WAIT_A,
        WAIT_B    = ST_WAIT_B,
        WAIT_OP   = ST_WAIT_OP,
        EXEC      = ST_EXEC,
        SEND_WAIT = ST_SEND_WAIT
    } state_e;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// rtl/uart_alu_sequencer_if.sv - UART/ALU side signal bundle of the sequencer
//
// Signals (named from the sequencer's point of view):
//   i_rx_done_tick / i_rx_data   byte strobe and byte from the UART receiver
//   i_alu_result                 combinational ALU output
//   i_tx_done_tick               transmitter finished a byte
//   o_data_a / o_data_b          registered ALU operands
//   o_operation                  registered ALU opcode
//   o_tx_start / o_tx_data       transmitter start pulse and byte
//   o_busy, o_error, o_overrun   status
// Modports: master = sequencer, slave = UART/ALU environment.
interface uart_alu_sequencer_if #(
    parameter int DBIT  = 8,
    parameter int NB_OP = 6
);
    logic             i_rx_done_tick;
    logic [DBIT-1:0]  i_rx_data;
    logic [DBIT-1:0]  i_alu_result;
    logic             i_tx_done_tick;
    logic [DBIT-1:0]  o_data_a;
    logic [DBIT-1:0]  o_data_b;
    logic [NB_OP-1:0] o_operation;
    logic             o_tx_start;
    logic [DBIT-1:0]  o_tx_data;
    logic             o_busy;
    logic             o_error;
    logic             o_overrun;

    modport master (
        input  i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
        output o_data_a, o_data_b, o_operation, o_tx_start, o_tx_data,
               o_busy, o_error, o_overrun
    );

    modport slave (
        output i_rx_done_tick, i_rx_data, i_alu_result, i_tx_done_tick,
        input  o_data_a, o_data_b, o_operation, o_tx_start, o_tx_data,
               o_busy, o_error, o_overrun
    );

endinterface

// File: rtl/uart_alu_sequencer_timeout.sv
// rtl/uart_alu_sequencer_timeout.sv - inter-byte timeout counter (module seq_timeout_counter)
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-low reset
//   clear_i          restart the count from zero (takes priority over count_en_i)
//   count_en_i       advance the count this cycle
//   expired_o        count has reached TIMEOUT_CYCLES-1 while counting is enabled
module seq_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - collects A/B/opcode bytes from the UART, drives the ALU, sends the result
//
// Ports:
//   i_clk     system clock
//   i_reset   synchronous, active-low reset
//   bus       uart_alu_sequencer_if.master (UART rx/tx, ALU operands/result, status)
// Build option: SEQ_TIMEOUT_EN adds an inter-byte timeout (TIMEOUT_CYCLES) that
// abandons a partial command with an o_error pulse.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int              DBIT     = 8,
    parameter int              NB_OP    = 6,
    parameter logic [DBIT-1:0] ERR_BYTE = DBIT'(ERR_BYTE_DEFAULT)
`ifdef SEQ_TIMEOUT_EN
    , parameter int            TIMEOUT_CYCLES = 50_000_000
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    uart_alu_sequencer_if.master  bus
);

    state_e           state_q, state_d;
    logic [DBIT-1:0]  data_a_q, data_a_d;
    logic [DBIT-1:0]  data_b_q, data_b_d;
    logic [NB_OP-1:0] op_q, op_d;
    logic [DBIT-1:0]  tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             error_q, error_d;
    logic             overrun_q, overrun_d;

    logic             rx_tick;
    logic             op_ok;
    logic             timeout_expired;

    assign rx_tick = bus.i_rx_done_tick;

    // The whole byte must be a legal opcode: nothing set above the opcode field.
    assign op_ok = ((bus.i_rx_data >> NB_OP) == '0) &&
                   is_valid_op(OP_W'(bus.i_rx_data[NB_OP-1:0]));

`ifdef SEQ_TIMEOUT_EN
    logic to_count_en;
    logic to_clear;
    logic to_expired;

    // Counting only happens mid-command; any other state holds the counter at zero,
    // which also covers the clear on entry to WAIT_A.
    assign to_count_en = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign to_clear    = rx_tick || !to_count_en;

    seq_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .clear_i    (to_clear),
        .count_en_i (to_count_en),
        .expired_o  (to_expired)
    );

    // A byte arriving on the expiry cycle rescues the command.
    assign timeout_expired = to_expired && !rx_tick;
`else
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        error_d    = 1'b0;
        overrun_d  = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (rx_tick) begin
                    data_a_d = bus.i_rx_data;
                    state_d  = WAIT_B;
                end
            end

            WAIT_B: begin
                if (rx_tick) begin
                    data_b_d = bus.i_rx_data;
                    state_d  = WAIT_OP;
                end else if (timeout_expired) begin
                    error_d = 1'b1;
                    state_d = WAIT_A;
                end
            end

            WAIT_OP: begin
                if (rx_tick) begin
                    if (op_ok) begin
                        op_d    = bus.i_rx_data[NB_OP-1:0];
                        state_d = EXEC;
                    end else begin
                        // Bad opcode: report it to the host instead of running the ALU.
                        tx_data_d  = ERR_BYTE;
                        tx_start_d = 1'b1;
                        error_d    = 1'b1;
                        state_d    = SEND_WAIT;
                    end
                end else if (timeout_expired) begin
                    error_d = 1'b1;
                    state_d = WAIT_A;
                end
            end

            EXEC: begin
                // Operands and opcode have been stable on the ALU for this cycle.
                tx_data_d  = bus.i_alu_result;
                tx_start_d = 1'b1;
                overrun_d  = rx_tick;
                state_d    = SEND_WAIT;
            end

            SEND_WAIT: begin
                overrun_d = rx_tick;
                // A done tick coincident with our own start pulse belongs to an
                // earlier byte, not the one we are launching.
                if (bus.i_tx_done_tick && !tx_start_q) begin
                    state_d = WAIT_A;
                end
            end

            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            error_q    <= error_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.o_data_a    = data_a_q;
    assign bus.o_data_b    = data_b_q;
    assign bus.o_operation = op_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_error     = error_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_busy      = (state_q == EXEC) || (state_q == SEND_WAIT);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - randomized self-checking bench for uart_alu_sequencer
module tb_uart_alu_sequencer;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;
    int overrun_seen;
    int exp_overruns;
    int double_pulses;
    logic start_prev;
    logic error_prev;
    logic [5:0] exp_op;

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    uart_alu_sequencer_if bus ();

`ifdef SEQ_TIMEOUT_EN
    uart_alu_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );
`else
    uart_alu_sequencer dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return sa >>> b;
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic op_legal(input logic [7:0] byte_in);
        if (byte_in[7:6] != 2'b00) return 1'b0;
        foreach (valid_ops[i]) if (valid_ops[i] == byte_in[5:0]) return 1'b1;
        return 1'b0;
    endfunction

    // Environment ALU seen by the DUT.
    assign bus.i_alu_result = alu_ref(bus.o_data_a, bus.o_data_b, bus.o_operation);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_overrun) overrun_seen++;
            if ((bus.o_tx_start && start_prev) || (bus.o_error && error_prev)) double_pulses++;
        end
        start_prev = bus.o_tx_start;
        error_prev = bus.o_error;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data      = b;
        bus.i_rx_done_tick = 1'b1;
        @(negedge clk);
        bus.i_rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bus.i_tx_done_tick = 1'b1;
        @(negedge clk);
        bus.i_tx_done_tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},       bus.o_data_a, 0);
        check({tag, "_b"},       bus.o_data_b, 0);
        check({tag, "_op"},      bus.o_operation, 0);
        check({tag, "_start"},   bus.o_tx_start, 0);
        check({tag, "_txdata"},  bus.o_tx_data, 0);
        check({tag, "_busy"},    bus.o_busy, 0);
        check({tag, "_error"},   bus.o_error, 0);
        check({tag, "_overrun"}, bus.o_overrun, 0);
    endtask

    // One full command. gap_ab/gap_bop: idle cycles between bytes.
    // early_done: pulse tx_done while o_tx_start is high (must be ignored).
    // extra_byte: push a byte into SEND_WAIT (must be dropped with an overrun).
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap_ab, input int gap_bop, input int done_delay,
                           input bit early_done, input bit extra_byte);
        logic ok;
        ok = op_legal(op);
        send_byte(a);
        idle(gap_ab);
        send_byte(b);
        idle(gap_bop);
        send_byte(op);
        if (ok) begin
            exp_op = op[5:0];
            check("exec_op", bus.o_operation, exp_op);
            check("exec_busy", bus.o_busy, 1);
            check("exec_nostart", bus.o_tx_start, 0);
            @(negedge clk);
        end
        check("start", bus.o_tx_start, 1);
        check("tx_data", bus.o_tx_data, ok ? alu_ref(a, b, op[5:0]) : 8'hEE);
        check("error", bus.o_error, !ok);
        check("op_hold", bus.o_operation, exp_op);
        check("data_a", bus.o_data_a, a);
        check("data_b", bus.o_data_b, b);
        if (early_done) pulse_tx_done();
        else @(negedge clk);
        check("start_1cyc", bus.o_tx_start, 0);
        check("send_busy", bus.o_busy, 1);
        if (extra_byte) begin
            send_byte(8'h55);
            exp_overruns++;
            check("overrun", bus.o_overrun, 1);
            check("overrun_a", bus.o_data_a, a);
            @(negedge clk);
            check("overrun_1cyc", bus.o_overrun, 0);
            check("overrun_busy", bus.o_busy, 1);
        end
        idle(done_delay);
        pulse_tx_done();
        check("done_idle", bus.o_busy, 0);
        check("done_txdata", bus.o_tx_data, ok ? alu_ref(a, b, op[5:0]) : 8'hEE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        n_checks = 0;
        n_fail = 0;
        overrun_seen = 0;
        exp_overruns = 0;
        double_pulses = 0;
        start_prev = 1'b0;
        error_prev = 1'b0;
        exp_op = '0;
        rst_n = 1'b0;
        bus.i_rx_done_tick = 1'b0;
        bus.i_rx_data = '0;
        bus.i_tx_done_tick = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // ADD, with a tx_done arriving alongside o_tx_start that must be ignored.
        run_cmd(8'h05, 8'h03, 8'h20, 0, 0, 2, 1'b1, 1'b0);

        // Opcode byte with upper bits set.
        run_cmd(8'h01, 8'h02, 8'hC0, 1, 0, 1, 1'b0, 1'b0);

        // Byte during SEND_WAIT, then a normal command.
        run_cmd(8'h07, 8'h02, 8'h24, 0, 2, 1, 1'b0, 1'b1);
        run_cmd(8'h09, 8'h04, 8'h26, 0, 0, 0, 1'b0, 1'b0);

        // Reset after operand A only.
        send_byte(8'h33);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_op = '0;
        check_all_zero("midreset");
        run_cmd(8'h0A, 8'h04, 8'h22, 0, 0, 1, 1'b0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        // A then 16 idle cycles: abandoned with an error, nothing sent.
        send_byte(8'h11);
        early = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.o_error || bus.o_tx_start) early++;
        end
        @(negedge clk);
        check("to_early", early, 0);
        check("to_error", bus.o_error, 1);
        check("to_nostart", bus.o_tx_start, 0);
        check("to_busy", bus.o_busy, 0);
        @(negedge clk);
        check("to_error_1cyc", bus.o_error, 0);
        // B arriving exactly on the expiry cycle is accepted.
        run_cmd(8'h21, 8'h12, 8'h25, 15, 0, 1, 1'b0, 1'b0);
`endif

        // Back-to-back random valid commands.
        for (int i = 0; i < 100; i++) begin
            run_cmd(8'($urandom), 8'($urandom), {2'b00, valid_ops[$urandom_range(7)]},
                    $urandom_range(2), $urandom_range(2), $urandom_range(3), 1'b0, 1'b0);
        end

        idle(2);
        check("overrun_total", overrun_seen, exp_overruns);
        check("double_pulses", double_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
